// File: rtl/screen_to_float_map.sv
// Maps an unsigned screen coordinate to (x - HALF_SPAN) / HALF_SPAN as an IEEE-754 single.
// One conversion takes 28 cycles: normalise, 25 restoring-division steps, round, present.
module screen_to_float_map #(
  parameter int unsigned HALF_SPAN = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] input_integer,
  output logic        ready_out,
  output logic        data_valid_out,
  output logic [31:0] output_float,
  output logic        range_err_out
);

  localparam logic [16:0] HS17     = 17'(HALF_SPAN);
  localparam logic [8:0]  HS9      = 9'(HALF_SPAN);
  localparam logic [8:0]  SPAN2_9  = 9'(2 * HALF_SPAN);
  localparam logic [31:0] SPAN2_32 = 32'(2 * HALF_SPAN);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_ROUND, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [7:0]  m_q, m_d;
  logic        zero_q, zero_d;
  logic [7:0]  exp_q, exp_d;
  logic [16:0] r_q, r_d;
  logic [24:0] quo_q, quo_d;
  logic [31:0] out_float_q, out_float_d;
  logic        out_err_q, out_err_d;
  logic        ready_q, ready_d;

  logic [16:0] m17;
  logic [16:0] shifted [0:8];
  logic [8:0]  ge_k;
  logic [3:0]  k_sel;
  logic [8:0]  x9;
  logic        div_bit;
  logic        sticky;
  logic        round_inc;
  logic        round_ovf;
  logic [22:0] frac_rnd;
  logic [7:0]  exp_rnd;

  assign m17 = {9'd0, m_q};

  // Every candidate normalisation shift is evaluated in parallel; the smallest passing one wins.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_shift
      assign shifted[gi] = m17 << gi;
      assign ge_k[gi]    = (shifted[gi] >= HS17);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    err_d       = err_q;
    m_d         = m_q;
    zero_d      = zero_q;
    exp_d       = exp_q;
    r_d         = r_q;
    quo_d       = quo_q;
    out_float_d = out_float_q;
    out_err_d   = out_err_q;
    k_sel       = 4'd0;

    for (int i = 8; i >= 0; i--) begin
      if (ge_k[i]) k_sel = 4'(i);
    end

    x9        = (input_integer > SPAN2_32) ? SPAN2_9 : input_integer[8:0];
    div_bit   = (r_q >= HS17);
    sticky    = (r_q != 17'd0);
    round_inc = quo_q[0] & (sticky | quo_q[1]);
    // quo_q[24] is always the hidden 1, so overflow means the whole significand was all ones.
    round_ovf = round_inc & (&quo_q[24:1]);
    frac_rnd  = quo_q[23:1] + {22'd0, round_inc};
    exp_rnd   = round_ovf ? (exp_q + 8'd1) : exp_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in && ready_q) begin
          err_d   = (input_integer > SPAN2_32);
          sign_d  = (x9 < HS9);
          m_d     = (x9 < HS9) ? 8'(HS9 - x9) : 8'(x9 - HS9);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        zero_d  = (m_q == 8'd0);
        r_d     = shifted[k_sel];
        exp_d   = 8'd127 - {4'd0, k_sel};
        cnt_d   = 5'd0;
        quo_d   = 25'd0;
        state_d = S_DIV;
      end
      S_DIV: begin
        r_d   = div_bit ? ((r_q - HS17) << 1) : (r_q << 1);
        quo_d = {quo_q[23:0], div_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = S_ROUND;
      end
      S_ROUND: begin
        out_float_d = zero_q ? 32'd0 : {sign_q, exp_rnd, frac_rnd};
        out_err_d   = err_q;
        state_d     = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      m_q         <= 8'd0;
      zero_q      <= 1'b0;
      exp_q       <= 8'd0;
      r_q         <= 17'd0;
      quo_q       <= 25'd0;
      out_float_q <= 32'd0;
      out_err_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      m_q         <= m_d;
      zero_q      <= zero_d;
      exp_q       <= exp_d;
      r_q         <= r_d;
      quo_q       <= quo_d;
      out_float_q <= out_float_d;
      out_err_q   <= out_err_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_out      = ready_q;
  assign data_valid_out = (state_q == S_OUT);
  assign output_float   = out_float_q;
  assign range_err_out  = out_err_q;

endmodule

// File: tb/tb_screen_to_float_map.sv
// Directed bench for screen_to_float_map with HALF_SPAN=180; sweep uses a double-precision
// reference rounded to single with round-to-nearest-even.
module tb_screen_to_float_map;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] input_integer = 32'd0;
  logic        ready_out;
  logic        data_valid_out;
  logic [31:0] output_float;
  logic        range_err_out;

  int checks = 0;
  int errors = 0;

  screen_to_float_map #(.HALF_SPAN(180)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .input_integer (input_integer),
    .ready_out     (ready_out),
    .data_valid_out(data_valid_out),
    .output_float  (output_float),
    .range_err_out (range_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // (x - 180) / 180 computed in double, then rounded once more to single (RNE).
  function automatic logic [31:0] ref_single(input int x);
    real         q;
    logic [63:0] b;
    logic [52:0] mt;
    logic [24:0] s;
    logic [7:0]  e8;
    logic        g;
    logic        st;
    if (x == 180) return 32'd0;
    q  = (real'(x) - 180.0) / 180.0;
    b  = $realtobits(q);
    mt = {1'b1, b[51:0]};
    g  = mt[28];
    st = |mt[27:0];
    s  = {1'b0, mt[52:29]} + {24'd0, g & (st | mt[29])};
    e8 = 8'(int'(b[62:52]) - 1023 + 127);
    if (s[24]) begin
      e8 = e8 + 8'd1;
      s  = 25'd0;
    end
    return {b[63], e8, s[22:0]};
  endfunction

  // Entered and left on a negedge; checks latency, value, flag, pulse width and hold.
  task automatic convert(input logic [31:0] x, input logic [31:0] exp_f, input logic exp_err,
                         input string tag);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (ready_out !== 1'b1 && wait_cnt < 40) begin
      @(negedge clk_in);
      wait_cnt++;
    end
    check1({tag, "_ready"}, ready_out, 1'b1);
    valid_in      = 1'b1;
    input_integer = x;
    @(negedge clk_in);
    valid_in      = 1'b0;
    input_integer = 32'd0;
    lat = 1;
    while (data_valid_out !== 1'b1 && lat < 40) begin
      @(negedge clk_in);
      lat++;
    end
    check32({tag, "_latency"}, 32'(lat), 32'd28);
    check32({tag, "_float"}, output_float, exp_f);
    check1({tag, "_err"}, range_err_out, exp_err);
    $display("xfer %s x=%0d out=%h err=%b lat=%0d", tag, x, output_float, range_err_out, lat);
    @(negedge clk_in);
    check1({tag, "_pulse"}, data_valid_out, 1'b0);
    check32({tag, "_hold"}, output_float, exp_f);
  endtask

  initial begin
    int dv_seen;

    // Reset state
    repeat (3) @(negedge clk_in);
    check1("rst_ready", ready_out, 1'b0);
    check1("rst_valid", data_valid_out, 1'b0);
    check32("rst_float", output_float, 32'd0);
    check1("rst_err", range_err_out, 1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check1("rel_ready", ready_out, 1'b1);

    // Main function
    convert(32'd0,   32'hBF800000, 1'b0, "x0");
    convert(32'd90,  32'hBF000000, 1'b0, "x90");
    convert(32'd180, 32'h00000000, 1'b0, "x180");
    convert(32'd270, 32'h3F000000, 1'b0, "x270");
    convert(32'd360, 32'h3F800000, 1'b0, "x360");

    // Rounding; 181 gives 1/180
    convert(32'd240, 32'h3EAAAAAB, 1'b0, "x240");
    convert(32'd120, 32'hBEAAAAAB, 1'b0, "x120");
    convert(32'd181, 32'h3BB60B61, 1'b0, "x181");

    // Clamp
    convert(32'd1000,       32'h3F800000, 1'b1, "x1000");
    convert(32'd360,        32'h3F800000, 1'b0, "x360b");
    convert(32'hFFFFFFFF,   32'h3F800000, 1'b1, "xmax");
    convert(32'd361,        32'h3F800000, 1'b1, "x361");

    // Handshake: valid held high for several results
    valid_in      = 1'b1;
    input_integer = 32'd240;
    for (int c = 0; c < 96; c++) begin
      check1($sformatf("hs_ready_c%0d", c), ready_out, (c % 29) == 0);
      check1($sformatf("hs_valid_c%0d", c), data_valid_out, (c % 29) == 28);
      if ((c % 29) == 28) check32($sformatf("hs_float_c%0d", c), output_float, 32'h3EAAAAAB);
      @(negedge clk_in);
    end
    valid_in      = 1'b0;
    input_integer = 32'd0;
    convert(32'd270, 32'h3F000000, 1'b0, "post_hs");

    // Reset ten cycles into a conversion
    convert(32'd360, 32'h3F800000, 1'b0, "pre_rst");
    valid_in      = 1'b1;
    input_integer = 32'd0;
    @(negedge clk_in);
    valid_in      = 1'b0;
    repeat (9) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    check1("mid_rst_valid", data_valid_out, 1'b0);
    check32("mid_rst_float", output_float, 32'd0);
    check1("mid_rst_err", range_err_out, 1'b0);
    check1("mid_rst_ready", ready_out, 1'b0);
    @(negedge clk_in);
    check1("mid_rel_ready", ready_out, 1'b1);
    dv_seen = 0;
    for (int c = 0; c < 35; c++) begin
      if (data_valid_out === 1'b1) dv_seen++;
      @(negedge clk_in);
    end
    check32("aborted_no_valid", 32'(dv_seen), 32'd0);
    convert(32'd270, 32'h3F000000, 1'b0, "post_rst");

    // Full sweep against the reference model
    for (int x = 0; x <= 360; x++) begin
      convert(32'(x), ref_single(x), 1'b0, $sformatf("sweep%0d", x));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
